// File: rtl/xaddrgen_pkg.sv
// Shared definitions for the xmem address generators: widths, config layout, FSM encoding.
package xaddrgen_pkg;

    localparam int unsigned MEM_ADDR_W = 10;
    localparam int unsigned PERIOD_W   = 5;

    localparam int unsigned ADDRGEN_CONF_BITS = 4 * MEM_ADDR_W + 3 * PERIOD_W;

    localparam int unsigned CONF_ITER_OFS   = 0;
    localparam int unsigned CONF_PERIOD_OFS = CONF_ITER_OFS + MEM_ADDR_W;
    localparam int unsigned CONF_DUTY_OFS   = CONF_PERIOD_OFS + PERIOD_W;
    localparam int unsigned CONF_DELAY_OFS  = CONF_DUTY_OFS + PERIOD_W;
    localparam int unsigned CONF_START_OFS  = CONF_DELAY_OFS + PERIOD_W;
    localparam int unsigned CONF_SHIFT_OFS  = CONF_START_OFS + MEM_ADDR_W;
    localparam int unsigned CONF_INCR_OFS   = CONF_SHIFT_OFS + MEM_ADDR_W;

    // Packed config word; first field sits at the MSB, so iterations lands at offset 0.
    typedef struct packed {
        logic [MEM_ADDR_W-1:0] incr;
        logic [MEM_ADDR_W-1:0] shift;
        logic [MEM_ADDR_W-1:0] start;
        logic [PERIOD_W-1:0]   delay;
        logic [PERIOD_W-1:0]   duty;
        logic [PERIOD_W-1:0]   period;
        logic [MEM_ADDR_W-1:0] iterations;
    } addrgen_conf_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDelay = 2'd1,
        StRun   = 2'd2
    } addrgen_state_e;

    function automatic logic conf_empty(input logic [MEM_ADDR_W-1:0] iters,
                                        input logic [PERIOD_W-1:0]   per);
        return (iters == '0) || (per == '0);
    endfunction

endpackage

// File: rtl/xaddrgen_period_cnt.sv
// xperiod_cnt: loadable up-counter wrapping at limit-1 with a terminal-count flag.
module xperiod_cnt #(
    parameter int unsigned Width = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [Width-1:0] limit,
    output logic [Width-1:0] count,
    output logic             tc
);

    logic [Width-1:0] count_q;

    assign tc    = (count_q == (limit - Width'(1)));
    assign count = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= tc ? '0 : count_q + Width'(1);
        end
    end

endmodule

// File: rtl/xaddrgen.sv
// xaddrgen: two-level nested address/enable sequencer feeding one xmem port.
// Defining XADDRGEN_PAUSE_EN adds a pause input that freezes a running sequence.
module xaddrgen
    import xaddrgen_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  run,
`ifdef XADDRGEN_PAUSE_EN
    input  logic                  pause,
`endif
    input  logic [MEM_ADDR_W-1:0] iterations,
    input  logic [PERIOD_W-1:0]   period,
    input  logic [PERIOD_W-1:0]   duty,
    input  logic [PERIOD_W-1:0]   delay,
    input  logic [MEM_ADDR_W-1:0] start,
    input  logic [MEM_ADDR_W-1:0] shift,
    input  logic [MEM_ADDR_W-1:0] incr,
    output logic [MEM_ADDR_W-1:0] addr,
    output logic                  mem_en,
    output logic                  done
);

    addrgen_state_e        state_q;
    logic [MEM_ADDR_W-1:0] addr_q, iter_q, iter_cfg_q, shift_q, incr_q;
    logic [PERIOD_W-1:0]   period_q, duty_q, delay_q;
    logic                  mem_en_q, done_q, empty_q, paused_q;

    logic                  hold, live, cnt_clear, per_en, dly_en;
    logic                  per_tc, dly_tc, iter_last, run_empty;
    logic [PERIOD_W-1:0]   per_cnt, per_next, dly_cnt;
    logic [MEM_ADDR_W-1:0] step;
    logic                  unused_dly_cnt;

`ifdef XADDRGEN_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // A cycle is live when it was not entered under pause; only live cycles advance.
    assign live      = !paused_q;
    assign cnt_clear = init || ((state_q == StIdle) && run);
    assign per_en    = !init && (state_q == StRun) && !empty_q && live;
    assign dly_en    = !init && (state_q == StDelay) && live;

    assign run_empty = conf_empty(iterations, period);
    assign iter_last = (iter_q == (iter_cfg_q - MEM_ADDR_W'(1)));
    assign per_next  = per_tc ? '0 : per_cnt + PERIOD_W'(1);
    assign step      = (mem_en_q ? incr_q : '0) + (per_tc ? shift_q : '0);

    assign unused_dly_cnt = ^dly_cnt;

    xperiod_cnt #(
        .Width (PERIOD_W)
    ) u_dly_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (dly_en),
        .limit (delay_q),
        .count (dly_cnt),
        .tc    (dly_tc)
    );

    xperiod_cnt #(
        .Width (PERIOD_W)
    ) u_per_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (per_en),
        .limit (period_q),
        .count (per_cnt),
        .tc    (per_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            mem_en_q   <= 1'b0;
            done_q     <= 1'b1;
            iter_q     <= '0;
            iter_cfg_q <= '0;
            period_q   <= '0;
            duty_q     <= '0;
            delay_q    <= '0;
            shift_q    <= '0;
            incr_q     <= '0;
            empty_q    <= 1'b0;
            paused_q   <= 1'b0;
        end else if (init) begin
            state_q  <= StIdle;
            addr_q   <= start;
            mem_en_q <= 1'b0;
            done_q   <= 1'b1;
            iter_q   <= '0;
            paused_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (run) begin
                        iter_cfg_q <= iterations;
                        period_q   <= period;
                        duty_q     <= duty;
                        delay_q    <= delay;
                        shift_q    <= shift;
                        incr_q     <= incr;
                        empty_q    <= run_empty;
                        addr_q     <= start;
                        iter_q     <= '0;
                        done_q     <= 1'b0;
                        paused_q   <= 1'b0;
                        // An empty sequence skips the delay and retires on the next edge.
                        if (run_empty || (delay == '0)) begin
                            state_q  <= StRun;
                            mem_en_q <= !run_empty && (duty != '0);
                        end else begin
                            state_q  <= StDelay;
                            mem_en_q <= 1'b0;
                        end
                    end
                end
                StDelay: begin
                    paused_q <= hold;
                    if (live && dly_tc) begin
                        state_q  <= StRun;
                        mem_en_q <= !hold && (duty_q != '0);
                    end
                end
                StRun: begin
                    if (empty_q) begin
                        state_q  <= StIdle;
                        done_q   <= 1'b1;
                        mem_en_q <= 1'b0;
                    end else if (live) begin
                        if (per_tc && iter_last) begin
                            state_q  <= StIdle;
                            done_q   <= 1'b1;
                            mem_en_q <= 1'b0;
                            paused_q <= 1'b0;
                        end else begin
                            addr_q   <= addr_q + step;
                            mem_en_q <= !hold && (per_next < duty_q);
                            paused_q <= hold;
                            if (per_tc) begin
                                iter_q <= iter_q + MEM_ADDR_W'(1);
                            end
                        end
                    end else begin
                        // Resuming: re-emit the enable for the cycle that was held.
                        paused_q <= hold;
                        mem_en_q <= !hold && (per_cnt < duty_q);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign addr   = addr_q;
    assign mem_en = mem_en_q;
    assign done   = done_q;

endmodule

// File: tb/tb_xaddrgen.sv
// Directed self-checking bench for xaddrgen; the pause scenario is built with XADDRGEN_PAUSE_EN.
module tb_xaddrgen;
    import xaddrgen_pkg::*;

    logic                  clk, rst, init, run;
    logic [MEM_ADDR_W-1:0] iterations, start, shift, incr, addr;
    logic [PERIOD_W-1:0]   period, duty, delay;
    logic                  mem_en, done;
`ifdef XADDRGEN_PAUSE_EN
    logic                  pause;
`endif

    int checks = 0;
    int errors = 0;

    int exp2[9]    = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int exp3_a[8]  = '{8, 9, 10, 10, 10, 11, 12, 12};
    int exp3_e[8]  = '{1, 1, 0, 0, 1, 1, 0, 0};
    int exp4c[6]   = '{0, 1, 2, 0, 1, 2};
    int exp6[5]    = '{6, 7, 10, 11, 12};

    xaddrgen dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .run        (run),
`ifdef XADDRGEN_PAUSE_EN
        .pause      (pause),
`endif
        .iterations (iterations),
        .period     (period),
        .duty       (duty),
        .delay      (delay),
        .start      (start),
        .shift      (shift),
        .incr       (incr),
        .addr       (addr),
        .mem_en     (mem_en),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int a, input logic e, input logic d);
        check({tag, ".addr"}, 32'(addr), a);
        check({tag, ".mem_en"}, 32'(mem_en), 32'(e));
        check({tag, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic set_conf(input int it, input int pe, input int du, input int de,
                            input int st, input int sh, input int inc);
        iterations = MEM_ADDR_W'(it);
        period     = PERIOD_W'(pe);
        duty       = PERIOD_W'(du);
        delay      = PERIOD_W'(de);
        start      = MEM_ADDR_W'(st);
        shift      = MEM_ADDR_W'(sh);
        incr       = MEM_ADDR_W'(inc);
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    initial begin
        rst  = 1'b0;
        init = 1'b0;
        run  = 1'b0;
`ifdef XADDRGEN_PAUSE_EN
        pause = 1'b0;
`endif
        set_conf(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_out("reset", 0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        check_out("idle", 0, 1'b0, 1'b1);

        // 3 periods of 3 fully enabled cycles, shift 2
        set_conf(3, 3, 3, 0, 0, 2, 1);
        pulse_run();
        for (int k = 0; k < 9; k++) begin
            check_out($sformatf("seq3x3[%0d]", k), exp2[k], 1'b1, 1'b0);
            tick();
        end
        check_out("seq3x3_done", 12, 1'b0, 1'b1);
        tick();
        check_out("seq3x3_idle", 12, 1'b0, 1'b1);

        // Asynchronous reset mid-sequence
        pulse_run();
        tick();
        tick();
        check_out("pre_reset", 2, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        check_out("async_reset", 0, 1'b0, 1'b1);
        tick();
        check_out("reset_held", 0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        check_out("reset_released", 0, 1'b0, 1'b1);

        // Duty 2 of 4 with 3 delay cycles
        set_conf(2, 4, 2, 3, 8, 0, 1);
        pulse_run();
        for (int k = 0; k < 3; k++) begin
            check_out($sformatf("delay[%0d]", k), 8, 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            check_out($sformatf("duty[%0d]", k), exp3_a[k], exp3_e[k][0], 1'b0);
            tick();
        end
        check_out("duty_done", 12, 1'b0, 1'b1);

        // iterations == 0: no enable, done low for one cycle
        set_conf(0, 3, 3, 0, 5, 0, 1);
        pulse_run();
        check("iter0_busy.mem_en", 32'(mem_en), 0);
        check("iter0_busy.done", 32'(done), 0);
        tick();
        check("iter0_done.mem_en", 32'(mem_en), 0);
        check("iter0_done.done", 32'(done), 1);

        // Address wrap at the top of the space
        set_conf(1, 2, 2, 0, 1023, 0, 1);
        pulse_run();
        check_out("wrap[0]", 1023, 1'b1, 1'b0);
        tick();
        check_out("wrap[1]", 0, 1'b1, 1'b0);
        tick();
        check_out("wrap_done", 0, 1'b0, 1'b1);

        // Negative shift rewinds each row
        set_conf(2, 3, 3, 0, 0, 'h3FD, 1);
        pulse_run();
        for (int k = 0; k < 6; k++) begin
            check_out($sformatf("negshift[%0d]", k), exp4c[k], 1'b1, 1'b0);
            tick();
        end
        check_out("negshift_done", 2, 1'b0, 1'b1);

        // init aborts a running sequence and loads the current start input
        set_conf(3, 3, 3, 0, 0, 2, 1);
        pulse_run();
        start = 10'd7;
        tick();
        tick();
        tick();
        check_out("abort_pre", 5, 1'b1, 1'b0);
        init = 1'b1;
        tick();
        init = 1'b0;
        check_out("abort", 7, 1'b0, 1'b1);
        tick();
        check_out("abort_idle", 7, 1'b0, 1'b1);

        // init and run together: init wins
        init = 1'b1;
        run  = 1'b1;
        tick();
        init = 1'b0;
        run  = 1'b0;
        check_out("init_run", 7, 1'b0, 1'b1);
        tick();
        check_out("init_run_idle", 7, 1'b0, 1'b1);

        // run and config changes while busy are ignored
        set_conf(3, 3, 3, 0, 0, 2, 1);
        pulse_run();
        for (int k = 0; k < 9; k++) begin
            check_out($sformatf("busyrun[%0d]", k), exp2[k], 1'b1, 1'b0);
            if (k == 3) begin
                run   = 1'b1;
                incr  = 10'd5;
                start = 10'd50;
            end else begin
                run = 1'b0;
            end
            tick();
        end
        run = 1'b0;
        check_out("busyrun_done", 12, 1'b0, 1'b1);

`ifdef XADDRGEN_PAUSE_EN
        // Pause for 5 cycles after the third access
        set_conf(3, 3, 3, 0, 0, 2, 1);
        pulse_run();
        tick();
        tick();
        check_out("pause_pre", 2, 1'b1, 1'b0);
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out($sformatf("paused[%0d]", k), 5, 1'b0, 1'b0);
        end
        pause = 1'b0;
        tick();
        check_out("resume", 5, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out($sformatf("resumed[%0d]", k), exp6[k], 1'b1, 1'b0);
        end
        tick();
        check_out("pause_done", 12, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
